calc_entry_sequencer: RTL and testbench

Consumes the debounced key stream (4-bit keycode + 1-cycle keypressed strobe) from the keypad scanner and turns it into calculator operations. Accumulates decimal digits into binary operands, captures the operator, issues {operand_a, operand_b, opcode} to the ALU over a valid/ready handshake, and accepts the result for display and chaining. Sits between the keypad scanner and the ALU/display path.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/calc_entry_sequencer_if.sv | 26 ++
 rtl/key_fifo.sv | 55 +++++
 rtl/calc_entry_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_calc_entry_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and key decoding for the calculator entry sequencer.
package calc_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_ISSUE,
        ST_WAIT_RESULT,
        ST_SHOW_RESULT
    } state_t;

    localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [KEY_W-1:0] KEY_ADD       = 4'hA;
    localparam logic [KEY_W-1:0] KEY_DIV       = 4'hD;
    localparam logic [KEY_W-1:0] KEY_EQ        = 4'hE;
    localparam logic [KEY_W-1:0] KEY_CLR       = 4'hF;

    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= KEY_DIGIT_MAX;
    endfunction

    function automatic logic is_operator(input logic [KEY_W-1:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    // Operator keys A..D map in order onto ADD..DIV.
    function automatic opcode_t key_to_op(input logic [KEY_W-1:0] key);
        return opcode_t'(2'(key - KEY_ADD));
    endfunction

endpackage

// File: rtl/calc_entry_sequencer_if.sv
// Key stream, ALU handshake and display signals of the entry sequencer.
interface calc_entry_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic [3:0]        keycode;
    logic              keypressed;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [1:0]        opcode;
    logic [DATA_W-1:0] result_in;
    logic              result_valid;
    logic [DATA_W-1:0] display_value;
    logic              key_dropped;

    modport master (
        input  keycode, keypressed, op_ready, result_in, result_valid,
        output op_valid, operand_a, operand_b, opcode, display_value, key_dropped
    );

    modport slave (
        output keycode, keypressed, op_ready, result_in, result_valid,
        input  op_valid, operand_a, operand_b, opcode, display_value, key_dropped
    );
endinterface

// File: rtl/key_fifo.sv
// Small key queue with synchronous flush; only built with CALC_ENTRY_KEY_FIFO_EN.
`ifdef CALC_ENTRY_KEY_FIFO_EN
module key_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is accepted when a pop frees a slot the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end
endmodule
`endif

// File: rtl/calc_entry_sequencer.sv
// Turns debounced keypad presses into ALU operations and display values.
// Optional CALC_ENTRY_KEY_FIFO_EN queues keys that arrive while an operation is in flight.
module calc_entry_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    calc_entry_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    state_t            state_q,         state_nxt;
    logic [DATA_W-1:0] operand_a_q,     operand_a_nxt;
    logic [DATA_W-1:0] operand_b_q,     operand_b_nxt;
    opcode_t           opcode_q,        opcode_nxt;
    opcode_t           pending_op_q,    pending_op_nxt;
    logic              has_pending_q,   has_pending_nxt;
    logic              clear_pending_q, clear_pending_nxt;
    logic [CNT_W-1:0]  digit_cnt_q,     digit_cnt_nxt;
    logic [DATA_W-1:0] display_q,       display_nxt;
    logic              key_dropped_q,   key_dropped_nxt;
    logic              op_valid_q,      op_valid_nxt;

    logic              busy;
    logic              in_entry;
    logic              clr_now;
    logic              key_vld;
    logic [KEY_W-1:0]  key_val;
    logic              fifo_drop;
    logic              digit_room;
    logic              do_clear;
    logic [DATA_W-1:0] a_mac_c;
    logic [DATA_W-1:0] b_mac_c;

    assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RESULT);
    assign in_entry   = !busy;
    assign clr_now    = bus.keypressed && (bus.keycode == KEY_CLR);
    assign digit_room = (digit_cnt_q < CNT_W'(MAX_DIGITS));
    assign a_mac_c    = operand_a_q * DATA_W'(10) + DATA_W'(key_val);
    assign b_mac_c    = operand_b_q * DATA_W'(10) + DATA_W'(key_val);

`ifdef CALC_ENTRY_KEY_FIFO_EN
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [KEY_W-1:0] fifo_head;
    logic             key_in;
    logic             key_to_fifo;

    key_fifo #(
        .DEPTH (4),
        .W     (KEY_W)
    ) u_key_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clr_now),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.keycode),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Queued keys take priority over fresh ones so press order is preserved.
    always_comb begin
        key_in      = bus.keypressed && !clr_now;
        key_to_fifo = key_in && (busy || !fifo_empty);
        fifo_pop    = in_entry && !fifo_empty && !clr_now;
        fifo_push   = key_to_fifo && (!fifo_full || fifo_pop);
        fifo_drop   = key_to_fifo && fifo_full && !fifo_pop;
        key_vld     = fifo_pop || (key_in && in_entry && fifo_empty);
        key_val     = fifo_pop ? fifo_head : bus.keycode;
    end
`else
    always_comb begin
        key_vld   = bus.keypressed && !clr_now;
        key_val   = bus.keycode;
        fifo_drop = 1'b0;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_ENTER_A;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
            opcode_q        <= OP_ADD;
            pending_op_q    <= OP_ADD;
            has_pending_q   <= 1'b0;
            clear_pending_q <= 1'b0;
            digit_cnt_q     <= '0;
            display_q       <= '0;
            key_dropped_q   <= 1'b0;
            op_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            operand_a_q     <= operand_a_nxt;
            operand_b_q     <= operand_b_nxt;
            opcode_q        <= opcode_nxt;
            pending_op_q    <= pending_op_nxt;
            has_pending_q   <= has_pending_nxt;
            clear_pending_q <= clear_pending_nxt;
            digit_cnt_q     <= digit_cnt_nxt;
            display_q       <= display_nxt;
            key_dropped_q   <= key_dropped_nxt;
            op_valid_q      <= op_valid_nxt;
        end
    end

    always_comb begin
        state_nxt         = state_q;
        operand_a_nxt     = operand_a_q;
        operand_b_nxt     = operand_b_q;
        opcode_nxt        = opcode_q;
        pending_op_nxt    = pending_op_q;
        has_pending_nxt   = has_pending_q;
        clear_pending_nxt = clear_pending_q;
        digit_cnt_nxt     = digit_cnt_q;
        display_nxt       = display_q;
        key_dropped_nxt   = fifo_drop;
        do_clear          = 1'b0;

        // Key handling; clear while busy is deferred until the result returns.
        if (clr_now) begin
            if (busy) clear_pending_nxt = 1'b1;
            else      do_clear          = 1'b1;
        end else if (key_vld) begin
            case (state_q)
                ST_ENTER_A: begin
                    if (is_digit(key_val)) begin
                        if (digit_room) begin
                            operand_a_nxt = a_mac_c;
                            display_nxt   = a_mac_c;
                            digit_cnt_nxt = digit_cnt_q + CNT_W'(1);
                        end
                    end else if (is_operator(key_val)) begin
                        opcode_nxt    = key_to_op(key_val);
                        operand_b_nxt = '0;
                        digit_cnt_nxt = '0;
                        state_nxt     = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (is_digit(key_val)) begin
                        if (digit_room) begin
                            operand_b_nxt = b_mac_c;
                            display_nxt   = b_mac_c;
                            digit_cnt_nxt = digit_cnt_q + CNT_W'(1);
                        end
                    end else if (is_operator(key_val)) begin
                        if (digit_cnt_q == '0) begin
                            opcode_nxt = key_to_op(key_val);
                        end else begin
                            pending_op_nxt  = key_to_op(key_val);
                            has_pending_nxt = 1'b1;
                            state_nxt       = ST_ISSUE;
                        end
                    end else if (key_val == KEY_EQ && digit_cnt_q != '0) begin
                        has_pending_nxt = 1'b0;
                        state_nxt       = ST_ISSUE;
                    end
                end
                ST_SHOW_RESULT: begin
                    if (is_digit(key_val)) begin
                        operand_a_nxt = DATA_W'(key_val);
                        display_nxt   = DATA_W'(key_val);
                        digit_cnt_nxt = CNT_W'(1);
                        state_nxt     = ST_ENTER_A;
                    end else if (is_operator(key_val)) begin
                        opcode_nxt    = key_to_op(key_val);
                        operand_b_nxt = '0;
                        digit_cnt_nxt = '0;
                        state_nxt     = ST_ENTER_B;
                    end
                end
                default: key_dropped_nxt = 1'b1;
            endcase
        end

        // ALU side of the transaction.
        case (state_q)
            ST_ISSUE: begin
                if (op_valid_q && bus.op_ready) state_nxt = ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT: begin
                if (bus.result_valid) begin
                    if (clear_pending_q || clr_now) begin
                        do_clear = 1'b1;
                    end else begin
                        operand_a_nxt = bus.result_in;
                        display_nxt   = bus.result_in;
                        digit_cnt_nxt = '0;
                        if (has_pending_q) begin
                            opcode_nxt      = pending_op_q;
                            operand_b_nxt   = '0;
                            has_pending_nxt = 1'b0;
                            state_nxt       = ST_ENTER_B;
                        end else begin
                            state_nxt = ST_SHOW_RESULT;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (do_clear) begin
            state_nxt         = ST_ENTER_A;
            operand_a_nxt     = '0;
            operand_b_nxt     = '0;
            opcode_nxt        = OP_ADD;
            pending_op_nxt    = OP_ADD;
            has_pending_nxt   = 1'b0;
            clear_pending_nxt = 1'b0;
            digit_cnt_nxt     = '0;
            display_nxt       = '0;
        end

        op_valid_nxt = (state_nxt == ST_ISSUE);
    end

    assign bus.op_valid      = op_valid_q;
    assign bus.operand_a     = operand_a_q;
    assign bus.operand_b     = operand_b_q;
    assign bus.opcode        = opcode_q;
    assign bus.display_value = display_q;
    assign bus.key_dropped   = key_dropped_q;
endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Scoreboard bench for calc_entry_sequencer: expected ALU ops queued, monitor compares at handshake.
module tb_calc_entry_sequencer;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } op_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   drop_seen = 0;
    int   exp_drops = 0;
    int   op_valid_cycles = 0;
    op_t  exp_q [$];

    calc_entry_sequencer_if #(.DATA_W(16)) bus ();

    calc_entry_sequencer #(
        .DATA_W     (16),
        .MAX_DIGITS (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted operation must match the head of the expected queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.op_valid) op_valid_cycles++;
            if (bus.key_dropped) drop_seen++;
            if (bus.op_valid && bus.op_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_op: got a=%0d b=%0d op=%0d with nothing expected",
                             bus.operand_a, bus.operand_b, bus.opcode);
                end else begin
                    op_t e;
                    e = exp_q.pop_front();
                    if (bus.operand_a !== e.a || bus.operand_b !== e.b || bus.opcode !== e.op) begin
                        errors++;
                        $display("FAIL alu_op: got a=%0d b=%0d op=%0d expected a=%0d b=%0d op=%0d",
                                 bus.operand_a, bus.operand_b, bus.opcode, e.a, e.b, e.op);
                    end
                end
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(posedge clock); #1;
        bus.keycode    = k;
        bus.keypressed = 1'b1;
        @(posedge clock); #1;
        bus.keypressed = 1'b0;
    endtask

    task automatic expect_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        op_t e;
        e.a = a; e.b = b; e.op = op;
        exp_q.push_back(e);
    endtask

    task automatic wait_handshake();
        int n;
        n = 0;
        while (!(bus.op_valid && bus.op_ready) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got op_valid=%0d op_ready=%0d required both 1",
                     bus.op_valid, bus.op_ready);
        end else begin
            @(posedge clock); #1;
        end
    endtask

    task automatic give_result(input logic [15:0] r);
        bus.result_in    = r;
        bus.result_valid = 1'b1;
        @(posedge clock); #1;
        bus.result_valid = 1'b0;
    endtask

    task automatic alu_respond(input logic [15:0] r);
        wait_handshake();
        give_result(r);
    endtask

    task automatic check_drops(input string name);
        @(posedge clock); #1;
        check(name, 32'(drop_seen), 32'(exp_drops));
    endtask

    initial begin
        int v0;
        bus.keycode      = 4'h0;
        bus.keypressed   = 1'b0;
        bus.op_ready     = 1'b1;
        bus.result_in    = 16'h0;
        bus.result_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_op_valid", 32'(bus.op_valid), 0);
        check("rst_display", 32'(bus.display_value), 0);
        check("rst_operand_a", 32'(bus.operand_a), 0);
        check("rst_operand_b", 32'(bus.operand_b), 0);
        check("rst_opcode", 32'(bus.opcode), 0);
        check("rst_key_dropped", 32'(bus.key_dropped), 0);

        // 12 + 3 =
        v0 = op_valid_cycles;
        press(4'h1); press(4'h2);
        check("t1_display_a", 32'(bus.display_value), 12);
        press(4'hA); press(4'h3);
        check("t1_display_b", 32'(bus.display_value), 3);
        expect_op(16'd12, 16'd3, 2'b00);
        press(4'hE);
        alu_respond(16'd15);
        check("t1_display_res", 32'(bus.display_value), 15);
        check("t1_op_valid_cycles", 32'(op_valid_cycles - v0), 1);
        check("t1_op_valid_low", 32'(bus.op_valid), 0);
        press(4'h7);
        check("t1_digit_restart", 32'(bus.display_value), 7);
        check("t1_restart_a", 32'(bus.operand_a), 7);
        press(4'hF);
        check("t1_clear", 32'(bus.display_value), 0);

        // Fifth digit ignored silently
        for (int i = 0; i < 5; i++) press(4'h9);
        check("t2_max_digits", 32'(bus.operand_a), 9999);
        check("t2_display", 32'(bus.display_value), 9999);
        check_drops("t2_no_drop");
        press(4'hF);

        // Operator replacement and chaining: 8 C D 2 B -> 8/2, then 4-1
        press(4'h8); press(4'hC); press(4'hD); press(4'h2);
        expect_op(16'd8, 16'd2, 2'b11);
        press(4'hB);
        alu_respond(16'd4);
        check("t3_chain_display", 32'(bus.display_value), 4);
        check("t3_chain_a", 32'(bus.operand_a), 4);
        check("t3_chain_opcode", 32'(bus.opcode), 1);
        press(4'h1);
        expect_op(16'd4, 16'd1, 2'b01);
        press(4'hE);
        alu_respond(16'd3);
        check("t3_final_display", 32'(bus.display_value), 3);
        press(4'hF);

        // Stall in ISSUE, drop a digit, queue a clear
        bus.op_ready = 1'b0;
        press(4'h4); press(4'hA); press(4'h5);
        expect_op(16'd4, 16'd5, 2'b00);
        press(4'hE);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("t4_hold_valid", 32'(bus.op_valid), 1);
            check("t4_hold_a", 32'(bus.operand_a), 4);
        end
        check("t4_hold_b", 32'(bus.operand_b), 5);
        press(4'h5);
`ifndef CALC_ENTRY_KEY_FIFO_EN
        exp_drops++;
`endif
        check_drops("t4_drop");
        press(4'hF);
        check("t4_valid_kept", 32'(bus.op_valid), 1);
        bus.op_ready = 1'b1;
        alu_respond(16'd9);
        check("t4_clear_display", 32'(bus.display_value), 0);
        check("t4_clear_a", 32'(bus.operand_a), 0);
        check("t4_clear_b", 32'(bus.operand_b), 0);
        check("t4_clear_opcode", 32'(bus.opcode), 0);
        press(4'h2);
        check("t4_enter_a", 32'(bus.display_value), 2);
        press(4'hF);

        // Asynchronous reset during ISSUE
        bus.op_ready = 1'b0;
        press(4'h3); press(4'hA); press(4'h4); press(4'hE);
        check("t5_in_issue", 32'(bus.op_valid), 1);
        reset = 1'b1;
        #1;
        check("t5_reset_valid", 32'(bus.op_valid), 0);
        check("t5_reset_display", 32'(bus.display_value), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.op_ready = 1'b1;
        press(4'h6);
        check("t5_after_reset", 32'(bus.display_value), 6);
        press(4'hF);

        // Keys pressed while waiting for the result
        press(4'h1); press(4'hA); press(4'h2);
        expect_op(16'd1, 16'd2, 2'b00);
        press(4'hE);
        wait_handshake();
        press(4'h4); press(4'hA); press(4'h6);
`ifdef CALC_ENTRY_KEY_FIFO_EN
        give_result(16'd10);
        repeat (4) @(posedge clock);
        #1;
        check("t6_replay_a", 32'(bus.operand_a), 4);
        check("t6_replay_op", 32'(bus.opcode), 0);
        check("t6_replay_b", 32'(bus.operand_b), 6);
        check("t6_replay_display", 32'(bus.display_value), 6);
        expect_op(16'd4, 16'd6, 2'b00);
        press(4'hE);
        alu_respond(16'd10);
`else
        exp_drops += 3;
        give_result(16'd10);
`endif
        check("t6_display", 32'(bus.display_value), 10);
        check_drops("t6_drops");

        repeat (3) @(posedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 required earlier finish");
        $fatal(1);
    end
endmodule
